// File: rtl/bisqrt_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bisqrt_pkg                                                            |
// | Shared types, reset constants and saturating helpers for bisqrt.      |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package bisqrt_pkg;

   localparam int KW = 8;

   typedef logic [KW-1:0] cnt_t;

   localparam cnt_t CNT_INIT = cnt_t'(1 << (KW - 1));

   function automatic cnt_t sat_inc(input cnt_t v);
      return (v == '1) ? v : cnt_t'(v + cnt_t'(1));
   endfunction

   function automatic cnt_t sat_dec(input cnt_t v);
      return (v == '0) ? v : cnt_t'(v - cnt_t'(1));
   endfunction

   // Clamp to the range of a two's-complement value of the given width.
   function automatic int sat_s(input int v, input int bits);
      int lo;
      int hi;
      lo = -(1 << (bits - 1));
      hi = (1 << (bits - 1)) - 1;
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bisqrt_addie_ch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bisqrt_addie_ch                                                       |
// | One stochastic sqrt channel: B2U converter, ADDIE kernel, U2B output. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module bisqrt_addie_ch
   import bisqrt_pkg::*;
#(
   parameter int DEP_B2U = 3,
   parameter int DEP_SQ  = 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic          bipolar,
   input  logic [KW-1:0] rand_num,
   input  logic          in_bit,
   output logic          out_bit
);

   logic signed [DEP_B2U-1:0] acc_q, acc_d;
   logic                      in_u_q, in_u_d;
   cnt_t                      cnt_q, cnt_d;
   logic                      k_q, k_d;
   logic [DEP_SQ-1:0]         dly_q, dly_d;
   logic                      t_q, t_d;
   logic                      out_q, out_d;

   int   b2u_pre;
   logic b2u_u;
   logic sq;

   generate
      if (DEP_SQ == 1) begin : g_dly1
         assign dly_d = k_q;
      end else begin : g_dlyn
         assign dly_d = {dly_q[DEP_SQ-2:0], k_q};
      end
   endgenerate

   // Squared estimate: the kernel bit ANDed with an older copy of itself.
   assign sq = k_q & dly_q[DEP_SQ-1];

   always_comb begin
      b2u_pre = int'(acc_q) + (in_bit ? 1 : -1);
      b2u_u   = (b2u_pre >= 1);
      acc_d   = DEP_B2U'(sat_s(b2u_pre - int'(b2u_u), DEP_B2U));
      in_u_d  = bipolar ? b2u_u : in_bit;

      cnt_d = cnt_q;
      case ({in_u_q, sq})
         2'b10:   cnt_d = sat_inc(cnt_q);
         2'b01:   cnt_d = sat_dec(cnt_q);
         default: cnt_d = cnt_q;
      endcase

      k_d   = (cnt_q > rand_num);
      t_d   = k_q ? t_q : ~t_q;
      out_d = bipolar ? (k_q | t_q) : k_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         in_u_q <= 1'b0;
         cnt_q  <= CNT_INIT;
         k_q    <= 1'b0;
         dly_q  <= '0;
         t_q    <= 1'b0;
         out_q  <= 1'b0;
      end else if (clr) begin
         acc_q  <= '0;
         in_u_q <= 1'b0;
         cnt_q  <= CNT_INIT;
         k_q    <= 1'b0;
         dly_q  <= '0;
         t_q    <= 1'b0;
         out_q  <= 1'b0;
      end else if (en) begin
         acc_q  <= acc_d;
         in_u_q <= in_u_d;
         cnt_q  <= cnt_d;
         k_q    <= k_d;
         dly_q  <= dly_d;
         t_q    <= t_d;
         out_q  <= out_d;
      end
   end

   assign out_bit = out_q;

endmodule
`default_nettype wire

// File: rtl/bisqrt_addie_array.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bisqrt_addie_array                                                    |
// | CH-channel stochastic square root with enable, clear and warm-up flag.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module bisqrt_addie_array
   import bisqrt_pkg::*;
#(
   parameter int CH      = 4,
   parameter int W       = KW,
   parameter int DEP_B2U = 3,
   parameter int DEP_SQ  = 1,
   parameter int WARMUP  = 256
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            clr,
   input  logic            bipolar,
   input  logic [CH*W-1:0] randNum,
   input  logic [CH-1:0]   in,
   output logic [CH-1:0]   out,
   output logic            valid
);

   localparam int            CW     = $clog2(WARMUP + 1);
   localparam logic [CW-1:0] WU_MAX = CW'(WARMUP);

   logic [CW-1:0] wu_q, wu_d;

   generate
      for (genvar c = 0; c < CH; c++) begin : g_ch
         bisqrt_addie_ch #(
            .DEP_B2U (DEP_B2U),
            .DEP_SQ  (DEP_SQ)
         ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .clr      (clr),
            .bipolar  (bipolar),
            .rand_num (randNum[c*W +: W]),
            .in_bit   (in[c]),
            .out_bit  (out[c])
         );
      end
   endgenerate

   always_comb begin
      wu_d = wu_q;
      if (wu_q != WU_MAX) wu_d = wu_q + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wu_q <= '0;
      end else if (clr) begin
         wu_q <= '0;
      end else if (en) begin
         wu_q <= wu_d;
      end
   end

   assign valid = (wu_q == WU_MAX);

endmodule
`default_nettype wire

// File: tb/tb_bisqrt_addie_array.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bisqrt_addie_array                                                 |
// | Directed self-checking bench with an output scoreboard.               |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_bisqrt_addie_array;

   logic        clk;
   logic        rst;
   logic        en;
   logic        clr;
   logic        bipolar;
   logic [31:0] rand_s;
   logic [3:0]  in_s;
   logic [3:0]  out_s;
   logic        valid_s;

   bisqrt_addie_array #(
      .CH(4), .W(8), .DEP_B2U(3), .DEP_SQ(1), .WARMUP(256)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clr     (clr),
      .bipolar (bipolar),
      .randNum (rand_s),
      .in      (in_s),
      .out     (out_s),
      .valid   (valid_s)
   );

   wire [7:0] cnt0 = dut.g_ch[0].u_ch.cnt_q;
   wire [7:0] cnt1 = dut.g_ch[1].u_ch.cnt_q;
   wire [7:0] cnt2 = dut.g_ch[2].u_ch.cnt_q;
   wire [7:0] cnt3 = dut.g_ch[3].u_ch.cnt_q;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         due;
      logic [3:0] exp;
   } sb_t;

   sb_t        sb_q[$];
   int         nerr = 0;
   int         nchk = 0;
   int         cyc  = 0;
   bit         sb_arm = 0;
   logic [3:0] sb_exp = 4'h0;
   bit         meas = 0;
   int         ones[4];
   int         in_mode[4];
   int         thr = 64;
   bit         alt_ph = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      nchk++;
      assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=[%0d..%0d]", tag, obs, lo, hi);
      end
   endtask

   // Input streams: 0 = const 0, 1 = const 1, 2 = alternating, 3 = P(1)=thr/256.
   task automatic drive();
      for (int c = 0; c < 4; c++) begin
         rand_s[c*8 +: 8] = 8'($urandom_range(0, 254));
         case (in_mode[c])
            0:       in_s[c] = 1'b0;
            1:       in_s[c] = 1'b1;
            2:       in_s[c] = alt_ph;
            default: in_s[c] = ($urandom_range(0, 255) < thr);
         endcase
      end
      alt_ph = ~alt_ph;
   endtask

   task automatic tick();
      @(posedge clk);
      if (en) cyc++;
      #1;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         sb_t e;
         e = sb_q.pop_front();
         chk("sb_out", 32'(out_s), 32'(e.exp));
      end
      if (meas) for (int c = 0; c < 4; c++) ones[c] += int'(out_s[c]);
      drive();
      if (sb_arm) sb_q.push_back('{due: cyc + 3, exp: sb_exp});
   endtask

   task automatic measure(input int n);
      for (int c = 0; c < 4; c++) ones[c] = 0;
      meas = 1;
      repeat (n) tick();
      meas = 0;
   endtask

   task automatic set_modes(input int m0, input int m1, input int m2, input int m3);
      in_mode[0] = m0; in_mode[1] = m1; in_mode[2] = m2; in_mode[3] = m3;
   endtask

   task automatic wait_all_sat(input string tag, input int bound);
      int n;
      n = 0;
      while (!(cnt0 == 8'd255 && cnt1 == 8'd255 && cnt2 == 8'd255 && cnt3 == 8'd255)
             && n < bound) begin
         tick();
         n++;
      end
      chk(tag, 32'(cnt0 == 8'd255 && cnt1 == 8'd255 && cnt2 == 8'd255 && cnt3 == 8'd255), 32'd1);
   endtask

   task automatic sb_run(input logic [3:0] exp, input int n);
      sb_exp = exp;
      sb_arm = 1;
      repeat (n) tick();
      sb_arm = 0;
      repeat (4) tick();
   endtask

   logic [3:0] frz_out;
   logic [7:0] frz_cnt;
   logic       frz_valid;

   initial begin
      rst = 1'b0; en = 1'b0; clr = 1'b0; bipolar = 1'b0;
      in_s = 4'h0; rand_s = '0;
      set_modes(0, 0, 0, 0);

      // Reset state
      #3 rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_out", 32'(out_s), 32'h0);
      chk("rst_valid", 32'(valid_s), 32'h0);
      chk("rst_cnt0", 32'(cnt0), 32'd128);
      chk("rst_cnt1", 32'(cnt1), 32'd128);
      chk("rst_cnt2", 32'(cnt2), 32'd128);
      chk("rst_cnt3", 32'(cnt3), 32'd128);

      // Warm-up: valid rises after exactly 256 enabled cycles
      rst = 1'b0; en = 1'b1;
      drive();
      repeat (255) tick();
      chk("warm_255", 32'(valid_s), 32'h0);
      tick();
      chk("warm_256", 32'(valid_s), 32'h1);

      // Unipolar saturate high
      set_modes(1, 1, 1, 1);
      wait_all_sat("sat_hi_reach", 4000);
      sb_run(4'hF, 20);
      repeat (50) tick();
      chk("sat_hi_hold", 32'(cnt0), 32'd255);

      // Unipolar drain toward zero
      set_modes(0, 0, 0, 0);
      repeat (4000) tick();
      chk_rng("sat_lo_cnt0", int'(cnt0), 0, 39);
      measure(512);
      chk_rng("sat_lo_ones", ones[0] + ones[1] + ones[2] + ones[3], 0, 255);

      // Bipolar x=0: output settles to a balanced stream
      bipolar = 1'b1;
      set_modes(2, 2, 2, 2);
      repeat (64) tick();
      measure(2048);
      chk_rng("bip_zero_ch0", ones[0], 901, 1270);
      chk_rng("bip_zero_ch3", ones[3], 901, 1270);

      // Bipolar x=1: kernel saturates, output all ones
      set_modes(1, 1, 1, 1);
      wait_all_sat("bip_one_reach", 4000);
      sb_run(4'hF, 20);

      // Enable freeze mid-run
      bipolar = 1'b0;
      thr = 64;
      set_modes(3, 3, 3, 3);
      repeat (300) tick();
      frz_out = out_s; frz_cnt = cnt0; frz_valid = valid_s;
      en = 1'b0;
      repeat (50) tick();
      chk("frz_out", 32'(out_s), 32'(frz_out));
      chk("frz_cnt0", 32'(cnt0), 32'(frz_cnt));
      chk("frz_valid", 32'(valid_s), 32'(frz_valid));
      en = 1'b1;

      // Unipolar accuracy P=0.25 -> 0.50
      repeat (256) tick();
      measure(4096);
      for (int c = 0; c < 4; c++) chk_rng($sformatf("acc25_ch%0d", c), ones[c], 1884, 2212);

      // Unipolar accuracy P=0.64 -> 0.80
      thr = 164;
      repeat (512) tick();
      measure(4096);
      chk_rng("acc64_ch0", ones[0], 3113, 3441);
      chk_rng("acc64_ch2", ones[2], 3113, 3441);

      // Clear with enable low
      en = 1'b0; clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_cnt0", 32'(cnt0), 32'd128);
      chk("clr_cnt2", 32'(cnt2), 32'd128);
      chk("clr_out", 32'(out_s), 32'h0);
      chk("clr_valid", 32'(valid_s), 32'h0);
      en = 1'b1;

      // Channel isolation
      thr = 64;
      set_modes(1, 0, 3, 3);
      repeat (2000) tick();
      measure(4096);
      chk_rng("iso_ch0", ones[0], 3687, 4096);
      chk_rng("iso_ch1", ones[1], 0, 614);
      chk_rng("iso_ch2", ones[2], 1843, 2253);
      chk_rng("iso_ch3", ones[3], 1843, 2253);

      // Asynchronous reset mid-stream
      #2 rst = 1'b1;
      #1;
      chk("arst_out", 32'(out_s), 32'h0);
      chk("arst_valid", 32'(valid_s), 32'h0);
      chk("arst_cnt0", 32'(cnt0), 32'd128);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire
